// File: rtl/phy_tx_lane_sched.sv
// phy_tx_lane_sched: four-lane round-robin TX scheduler.
// Each lane owns a small FIFO; one word per cycle is drained into a
// registered output slot in fair rotation, with IDLE fill when all lanes
// are empty. Per-lane pause and sticky overflow flags go back upstream.

// Per-lane circular FIFO with occupancy count and sticky overflow flag.
module phy_tx_lane_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_vld_i,
  input  logic [7:0]    push_data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic [CW-1:0] count_o,
  output logic          err_o
);
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          err_q;
  logic          full, do_push, do_pop;

  // Full is judged on the pre-edge count, so a same-cycle pop never
  // rescues a word that arrives while the lane is full.
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push_vld_i && !full;
  assign do_pop  = pop_i && (count_q != '0);

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      if (push_vld_i && full) err_q <= 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign err_o   = err_q;
endmodule

// Top: lane FIFO array, round-robin arbiter and registered output slot.
module phy_tx_lane_sched #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] IDLE  = 8'hBC
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [8:0] data0,
  input  logic [8:0] data1,
  input  logic [8:0] data2,
  input  logic [8:0] data3,
  input  logic       out_ready,
  output logic [8:0] out_data,
  output logic [1:0] lane_id,
  output logic [3:0] pause,
  output logic [3:0] err
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;

  logic [NUM_LANES-1:0][8:0]    lane_in;
  logic [NUM_LANES-1:0][7:0]    head;
  logic [NUM_LANES-1:0][CW-1:0] cnt;
  logic [NUM_LANES-1:0]         nonempty, pop, err_w;

  logic [8:0] out_data_q;
  logic [1:0] lane_id_q, last_grant_q;
  logic       grant_vld;
  logic [1:0] grant_idx, cand;

  assign lane_in = {data3, data2, data1, data0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    phy_tx_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk_4f),
      .reset_i     (reset),
      .push_vld_i  (lane_in[g][8]),
      .push_data_i (lane_in[g][7:0]),
      .pop_i       (pop[g]),
      .head_o      (head[g]),
      .count_o     (cnt[g]),
      .err_o       (err_w[g])
    );
    assign nonempty[g] = (cnt[g] != '0);
    assign pop[g]      = out_ready && grant_vld && (grant_idx == 2'(g));
    // Threshold at DEPTH-1 leaves upstream one cycle of slack.
    assign pause[g]    = (cnt[g] >= CW'(DEPTH - 1));
  end

  // Round-robin search starting one past the previous grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant_q;
    cand      = last_grant_q;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = last_grant_q + 2'(k);
      if (!grant_vld && nonempty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Output slot and grant history; everything holds while out_ready is low.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      out_data_q   <= {1'b0, IDLE};
      lane_id_q    <= 2'd0;
      last_grant_q <= 2'd3;
    end else if (out_ready) begin
      if (grant_vld) begin
        out_data_q   <= {1'b1, head[grant_idx]};
        lane_id_q    <= grant_idx;
        last_grant_q <= grant_idx;
      end else begin
        out_data_q   <= {1'b0, IDLE};
      end
    end
  end

  assign out_data = out_data_q;
  assign lane_id  = lane_id_q;
  assign err      = err_w;
endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// Directed bench for phy_tx_lane_sched with hand-computed expectations.
module tb_phy_tx_lane_sched;
  logic       clk_4f = 1'b0;
  logic       reset;
  logic [8:0] data0, data1, data2, data3;
  logic       out_ready;
  logic [8:0] out_data;
  logic [1:0] lane_id;
  logic [3:0] pause, err;

  int total = 0;
  int bad   = 0;

  phy_tx_lane_sched #(.DEPTH(4), .IDLE(8'hBC)) dut (
    .clk_4f(clk_4f), .reset(reset),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .out_ready(out_ready), .out_data(out_data), .lane_id(lane_id),
    .pause(pause), .err(err)
  );

  always #5 clk_4f = ~clk_4f;

  // Advance one edge and settle; inputs are then driven away from the edge.
  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic idle_inputs();
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_data !== 9'h0BC || lane_id !== 2'd0 || pause !== 4'h0 || err !== 4'h0) begin
      bad++;
      $display("FAIL reset: out=%h id=%0d pause=%b err=%b, want 0bc/0/0000/0000",
               out_data, lane_id, pause, err);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_data !== 9'h0BC || lane_id !== 2'd0 || pause !== 4'h0 || err !== 4'h0) begin
        bad++;
        $display("FAIL idle[%0d]: out=%h id=%0d pause=%b err=%b, want 0bc/0/0000/0000",
                 i, out_data, lane_id, pause, err);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    data2 = 9'h1A5;
    tick();                       // edge k: stored, not yet grantable
    data2 = '0;
    total++;
    if (out_data !== 9'h0BC) begin
      bad++; $display("FAIL single_k: out=%h want 0bc", out_data);
    end
    tick();                       // edge k+1
    total++;
    if (out_data !== 9'h1A5 || lane_id !== 2'd2) begin
      bad++; $display("FAIL single_k1: out=%h id=%0d want 1a5/2", out_data, lane_id);
    end
    tick();                       // edge k+2
    total++;
    if (out_data !== 9'h0BC || lane_id !== 2'd2) begin
      bad++; $display("FAIL single_k2: out=%h id=%0d want 0bc/2", out_data, lane_id);
    end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp [9] = '{9'h110, 9'h111, 9'h112, 9'h113,
                            9'h120, 9'h121, 9'h122, 9'h123, 9'h0BC};
    do_reset();
    data0 = 9'h110; data1 = 9'h111; data2 = 9'h112; data3 = 9'h113;
    tick();
    data0 = 9'h120; data1 = 9'h121; data2 = 9'h122; data3 = 9'h123;
    tick();
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (out_data !== exp[i] || (i < 8 && lane_id !== 2'(i % 4))) begin
        bad++;
        $display("FAIL rr[%0d]: out=%h id=%0d want %h/%0d", i, out_data, lane_id,
                 exp[i], i % 4);
      end
    end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_pause [5] = '{4'h0, 4'h0, 4'h2, 4'h2, 4'h2};
    logic [3:0] exp_err   [5] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      data1 = {1'b1, 8'h40 + 8'(i)};
      tick();
      total++;
      if (pause !== exp_pause[i] || err !== exp_err[i]) begin
        bad++;
        $display("FAIL ovf_push[%0d]: pause=%b err=%b want %b/%b", i, pause, err,
                 exp_pause[i], exp_err[i]);
      end
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (out_data !== ((i < 4) ? {1'b1, 8'h40 + 8'(i)} : 9'h0BC) || lane_id !== 2'd1) begin
        bad++;
        $display("FAIL ovf_drain[%0d]: out=%h id=%0d", i, out_data, lane_id);
      end
    end
    total++;
    if (err !== 4'h2 || pause !== 4'h0) begin
      bad++; $display("FAIL ovf_sticky: err=%b pause=%b want 0010/0000", err, pause);
    end
  endtask

  task automatic test_backpressure();
    logic       rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [8:0] exp [4] = '{9'h1A1, 9'h1A1, 9'h1A1, 9'h1B2};
    do_reset();
    data0 = 9'h1A1; tick();
    data0 = 9'h1B2; tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      out_ready = rdy[i];
      tick();
      total++;
      if (out_data !== exp[i] || lane_id !== 2'd0) begin
        bad++;
        $display("FAIL bp[%0d]: out=%h id=%0d want %h/0", i, out_data, lane_id, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      data0 = (i < 2) ? {1'b1, 8'h70 + 8'(i)} : 9'h0;
      data3 = {1'b1, 8'h80 + 8'(i)};
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    tick();
    total++;
    if (out_data !== 9'h170 || err !== 4'h8 || pause !== 4'h8) begin
      bad++; $display("FAIL mid_pre: out=%h err=%b pause=%b want 170/1000/1000",
                      out_data, err, pause);
    end
    reset = 1'b1;
    data3 = 9'h1FF;
    tick();
    reset = 1'b0;
    idle_inputs();
    total++;
    if (out_data !== 9'h0BC || err !== 4'h0 || pause !== 4'h0 || lane_id !== 2'd0) begin
      bad++; $display("FAIL mid_rst: out=%h err=%b pause=%b id=%0d want 0bc/0/0/0",
                      out_data, err, pause, lane_id);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (out_data !== 9'h0BC) begin
        bad++; $display("FAIL mid_stale[%0d]: out=%h want 0bc", i, out_data);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
